// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM state encoding and the
// IF/ID pipeline register layout seen by decode.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DROP
  } fetch_state_e;

  localparam logic [31:0] NOP_INSN_DEFAULT = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] instruct;
    logic [31:0] pc;
  } if_id_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for a fetched instruction that arrived while
// decode was stalled. Clear takes precedence over load.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_load,
  input  logic   i_clear,
  input  if_id_t i_data,
  output if_id_t o_data,
  output logic   o_full
);

  if_id_t buf_reg;
  logic   full_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      buf_reg  <= '0;
      full_reg <= 1'b0;
    end else if (i_load) begin
      buf_reg  <= i_data;
      full_reg <= 1'b1;
    end
  end

  assign o_data = buf_reg;
  assign o_full = full_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem request
// at a time and drives the IF/ID register consumed by decode.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = NOP_INSN_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_valid,
  output logic [31:0] o_instruct,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_four
);

  fetch_state_e state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  drop_addr_reg, drop_addr_next;
  if_id_t       if_id_reg, if_id_next;

  logic         skid_load, skid_clear, skid_full;
  if_id_t       skid_data;

  logic         slot_free;
  if_id_t       bubble;
  if_id_t       fetched;

  assign slot_free = !if_id_reg.valid || !i_stall;
  assign bubble    = '{valid: 1'b0, instruct: NOP_INSN, pc: if_id_reg.pc};
  assign fetched   = '{valid: 1'b1, instruct: i_imem_rdata, pc: pc_reg};

  fetch_skid_buf u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (skid_load),
    .i_clear (skid_clear),
    .i_data  (fetched),
    .o_data  (skid_data),
    .o_full  (skid_full)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= S_IDLE;
      pc_reg        <= RESET_PC;
      drop_addr_reg <= 32'h0;
      if_id_reg     <= '{valid: 1'b0, instruct: NOP_INSN, pc: 32'h0};
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      drop_addr_reg <= drop_addr_next;
      if_id_reg     <= if_id_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    drop_addr_next = drop_addr_reg;
    if_id_next     = if_id_reg;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;

    if (i_redirect) begin
      // Flush everything younger than the redirecting branch; stall is moot.
      pc_next    = {i_redirect_pc[31:2], 2'b00};
      if_id_next = bubble;
      skid_clear = 1'b1;
      case (state_reg)
        S_REQ: begin
          if (i_imem_ack) begin
            state_next = S_REQ;
          end else begin
            state_next     = S_DROP;
            drop_addr_next = pc_reg;
          end
        end
        S_DROP:  state_next = i_imem_ack ? S_REQ : S_DROP;
        default: state_next = S_REQ;
      endcase
    end else begin
      case (state_reg)
        S_IDLE: state_next = S_REQ;
        S_REQ: begin
          if (i_imem_ack) begin
            pc_next = pc_reg + 32'd4;
            if (slot_free) begin
              if_id_next = fetched;
            end else begin
              skid_load  = 1'b1;
              state_next = S_HOLD;
            end
          end else if (slot_free) begin
            if_id_next = bubble;
          end
        end
        S_HOLD: begin
          if (!i_stall) begin
            if_id_next = skid_full ? skid_data : bubble;
            skid_clear = 1'b1;
            state_next = S_REQ;
          end
        end
        S_DROP: begin
          // The stale response is swallowed; the redirected pc goes out next.
          if (i_imem_ack) begin
            state_next = S_REQ;
          end
          if (slot_free) begin
            if_id_next = bubble;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign o_imem_req  = (state_reg == S_REQ) || (state_reg == S_DROP);
  assign o_imem_addr = (state_reg == S_DROP) ? drop_addr_reg : pc_reg;

  assign o_valid    = if_id_reg.valid;
  assign o_instruct = if_id_reg.instruct;
  assign o_pc       = if_id_reg.pc;
  assign o_pc_four  = if_id_reg.pc + 32'd4;

`ifndef SYNTHESIS
  ack_without_req: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_imem_ack && !o_imem_req));
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a latency-controlled imem responder, directed
// scenarios, then random stall/redirect traffic against an in-order stream scoreboard.
module tb_fetch_stage;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] RESET_PC0 = 32'h0000_0000;

  logic        clk;
  logic        i_rst, i_stall, i_redirect, i_imem_ack;
  logic [31:0] i_redirect_pc, i_imem_rdata;
  logic        o_imem_req, o_valid;
  logic [31:0] o_imem_addr, o_instruct, o_pc, o_pc_four;

  logic        w_req, w_ack, w_valid;
  logic [31:0] w_addr, w_rdata, w_instruct, w_pc, w_pc_four;

  int          checks = 0;
  int          errors = 0;
  int          consumed = 0;
  int          wait_left = -1;
  int          lat_cfg = 0;
  logic        prev_ack = 1'b0;
  logic        checking_en = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] exp_next = RESET_PC0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  fetch_stage dut (
    .i_clk(clk), .i_rst(i_rst), .i_stall(i_stall), .i_redirect(i_redirect),
    .i_redirect_pc(i_redirect_pc), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata), .o_valid(o_valid),
    .o_instruct(o_instruct), .o_pc(o_pc), .o_pc_four(o_pc_four)
  );

  // Second instance exercises the PC wrap from the top of the address space.
  assign w_ack   = w_req;
  assign w_rdata = mem_word(w_addr);

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .i_clk(clk), .i_rst(i_rst), .i_stall(1'b0), .i_redirect(1'b0),
    .i_redirect_pc(32'h0), .o_imem_req(w_req), .o_imem_addr(w_addr),
    .i_imem_ack(w_ack), .i_imem_rdata(w_rdata), .o_valid(w_valid),
    .o_instruct(w_instruct), .o_pc(w_pc), .o_pc_four(w_pc_four)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies inputs just after a rising edge and returns at the following falling edge.
  task automatic step(input logic rst, input logic stall, input logic redir, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    prev_ack      = i_imem_ack;
    i_rst         = rst;
    i_stall       = stall;
    i_redirect    = redir;
    i_redirect_pc = tgt;
    i_imem_ack    = 1'b0;
    if (rst) begin
      wait_left = -1;
      exp_q.delete();
      exp_next = RESET_PC0;
    end else if (o_imem_req) begin
      if (wait_left < 0) wait_left = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
      if (wait_left == 0) begin
        i_imem_ack = 1'b1;
        wait_left  = -1;
      end else begin
        wait_left--;
      end
    end
    i_imem_rdata = i_imem_ack ? mem_word(o_imem_addr) : $urandom;
    if (redir && !rst) begin
      exp_q.delete();
      exp_next = {tgt[31:2], 2'b00};
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back(exp_next);
      exp_next = exp_next + 32'd4;
    end
    @(negedge clk);
  endtask

  // Monitor: protocol/format checks every cycle, scoreboard pop on each consumed insn.
  always @(negedge clk) begin
    if (checking_en) begin
      logic [31:0] e;
      if (!o_valid) check("bubble_is_nop", o_instruct, NOP);
      check("pc_four", o_pc_four, o_pc + 32'd4);
      if (pend) begin
        check("req_held", {31'b0, o_imem_req}, 32'd1);
        check("addr_stable", o_imem_addr, pend_addr);
      end
      pend      = !i_rst && o_imem_req && !i_imem_ack;
      pend_addr = o_imem_addr;
      if (!i_rst && o_valid && !i_stall && !i_redirect) begin
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL sb_empty: got pc %h expected none", o_pc);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", o_pc, e);
          check("sb_insn", o_instruct, mem_word(e));
          consumed++;
          $display("insn pc=%h data=%h", o_pc, o_instruct);
        end
      end
    end
  end

  initial begin
    int n;
    logic [31:0] p;
    i_rst = 1'b1; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'h0;
    i_imem_ack = 1'b0; i_imem_rdata = 32'h0;

    // Reset values
    step(1, 0, 0, 0);
    checking_en = 1'b1;
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_instruct", o_instruct, NOP);
    check("rst_pc", o_pc, 32'h0);
    check("rst_pc_four", o_pc_four, 32'd4);
    check("rst_req", {31'b0, o_imem_req}, 32'd0);
    check("wrap_rst_pc", w_pc, 32'h0);
    check("wrap_rst_pc_four", w_pc_four, 32'd4);

    // Zero-wait streaming
    step(0, 0, 0, 0);
    check("first_req", {31'b0, o_imem_req}, 32'd1);
    check("first_addr", o_imem_addr, 32'h0);
    check("first_valid", {31'b0, o_valid}, 32'd0);
    step(0, 0, 0, 0);
    check("stream_valid", {31'b0, o_valid}, 32'd1);
    check("stream_pc0", o_pc, 32'h0);
    check("wrap_pc_first", w_pc, 32'hFFFF_FFFC);
    check("wrap_pc_four_first", w_pc_four, 32'h0);
    step(0, 0, 0, 0);
    check("wrap_pc_second", w_pc, 32'h0);
    for (int k = 1; k < 7; k++) begin
      if (k > 1) step(0, 0, 0, 0);
      check("stream_valid", {31'b0, o_valid}, 32'd1);
      check("stream_pc", o_pc, 32'(4 * k));
      check("stream_addr", o_imem_addr, 32'(4 * k + 4));
    end

    // Two-cycle memory latency: valid only the cycle after each ack
    lat_cfg = 2;
    repeat (9) begin
      step(0, 0, 0, 0);
      check("valid_after_ack", {31'b0, o_valid}, {31'b0, prev_ack});
    end

    // Stall with a response arriving: skid capture, no request, in-order release
    lat_cfg = 0;
    n = 0;
    do begin step(0, 0, 0, 0); n++; end while (!i_imem_ack && n < 10);
    step(0, 1, 0, 0);
    check("stall_setup", {30'b0, o_valid, i_imem_ack}, 32'd3);
    p = exp_q[0];
    step(0, 1, 0, 0);
    check("stall_hold_pc", o_pc, p);
    check("stall_no_req", {31'b0, o_imem_req}, 32'd0);
    step(0, 1, 0, 0);
    check("stall_hold_pc", o_pc, p);
    check("stall_no_req", {31'b0, o_imem_req}, 32'd0);
    step(0, 0, 0, 0);
    check("stall_hold_pc", o_pc, p);
    step(0, 0, 0, 0);
    check("skid_release_pc", o_pc, p + 32'd4);
    check("skid_release_valid", {31'b0, o_valid}, 32'd1);

    // Redirect while a request is outstanding
    lat_cfg = 3;
    n = 0;
    do begin step(0, 0, 0, 0); n++; end while (!i_imem_ack && n < 20);
    step(0, 0, 1, 32'h0000_0103);
    check("redir_pending", {31'b0, i_imem_ack}, 32'd0);
    p = o_imem_addr;
    step(0, 0, 0, 0);
    check("drop_req", {31'b0, o_imem_req}, 32'd1);
    check("drop_addr", o_imem_addr, p);
    check("drop_valid", {31'b0, o_valid}, 32'd0);
    n = 0;
    while (!i_imem_ack && n < 10) begin
      step(0, 0, 0, 0);
      check("drop_valid", {31'b0, o_valid}, 32'd0);
      n++;
    end
    step(0, 0, 0, 0);
    check("redir_addr", o_imem_addr, 32'h0000_0100);
    check("redir_dropped", {31'b0, o_valid}, 32'd0);

    // Redirect + stall + ack in one cycle
    lat_cfg = 0;
    n = 0;
    do begin step(0, 0, 0, 0); n++; end while (!i_imem_ack && n < 10);
    step(0, 1, 1, 32'h0000_0200);
    check("rsa_setup", {30'b0, o_valid, i_imem_ack}, 32'd3);
    step(0, 0, 0, 0);
    check("rsa_bubble", {31'b0, o_valid}, 32'd0);
    check("rsa_nop", o_instruct, NOP);
    check("rsa_addr", o_imem_addr, 32'h0000_0200);
    step(0, 0, 0, 0);
    check("rsa_first_pc", o_pc, 32'h0000_0200);
    step(0, 0, 0, 0);
    check("rsa_second_pc", o_pc, 32'h0000_0204);

    // Reset in the middle of a memory wait
    lat_cfg = 3;
    n = 0;
    do begin step(0, 0, 0, 0); n++; end while (!i_imem_ack && n < 20);
    step(0, 0, 0, 0);
    check("midrst_waiting", {30'b0, o_imem_req, i_imem_ack}, 32'd2);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    check("midrst_valid", {31'b0, o_valid}, 32'd0);
    check("midrst_instruct", o_instruct, NOP);
    check("midrst_pc", o_pc, 32'h0);
    check("midrst_pc_four", o_pc_four, 32'd4);
    check("midrst_req", {31'b0, o_imem_req}, 32'd0);
    step(0, 0, 0, 0);
    check("midrst_restart_addr", o_imem_addr, RESET_PC0);

    // Random traffic
    lat_cfg = -1;
    n = consumed;
    repeat (3000) begin
      step(0, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 3, $urandom);
    end
    check("progress", {31'b0, (consumed - n) >= 300}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
